// File: rtl/door_access_ctrl.sv
// Keypad door-lock front end: synchronizes and debounces the 12-key pad, frames
// login entries for the lock core, drives the door strike and enforces lockout.
module door_access_ctrl #(
    parameter int DEBOUNCE    = 16,
    parameter int VERIFY_WAIT = 32,
    parameter int OPEN_HOLD   = 1000,
    parameter int LOCKOUT_CYC = 5000,
    parameter int MAX_FAIL    = 3,
    parameter int TW          = 24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [11:0] key_raw,
    input  logic        lock_open,
    output logic [11:0] key_out,
    output logic        lock_rst_n,
    output logic        door_release,
    output logic        locked_out,
    output logic        alarm,
    output logic [3:0]  fail_cnt
);

    localparam int DW = $clog2(DEBOUNCE + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRY,
        S_CHANGE,
        S_VERIFY,
        S_OPEN,
        S_RELOCK,
        S_LOCKOUT
    } state_t;

    logic [11:0]   sync1_q, sync2_q, cand_q, deb_q, deb_prev_q;
    logic [DW-1:0] stab_q;
    logic [11:0]   sync_clean;

    state_t        state_q;
    logic [3:0]    cnt_q;
    logic [TW-1:0] timer_q;
    logic [3:0]    fail_cnt_q;
    logic [3:0]    fail_inc;
    logic          lock_rst_n_q, door_q, lockout_q;
    logic          pass_thru, press, is_digit, is_star, is_hash, expire;

    // Chords and multi-key presses carry no meaning for the lock core.
    assign sync_clean = ((sync2_q & (sync2_q - 12'd1)) == 12'd0) ? sync2_q : 12'd0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            cand_q     <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            stab_q     <= '0;
        end else begin
            sync1_q    <= key_raw;
            sync2_q    <= sync1_q;
            deb_prev_q <= deb_q;
            if (sync_clean != cand_q) begin
                cand_q <= sync_clean;
                stab_q <= DW'(1);
            end else if (stab_q != DW'(DEBOUNCE)) begin
                stab_q <= stab_q + DW'(1);
                if (stab_q == DW'(DEBOUNCE - 1))
                    deb_q <= cand_q;
            end
        end
    end

    assign pass_thru = (state_q == S_IDLE) || (state_q == S_ENTRY) || (state_q == S_CHANGE);
    assign key_out   = pass_thru ? deb_q : 12'd0;
    // A key that became stable while blocked never counts; it must go back to 0 first.
    assign press     = pass_thru && (deb_prev_q == 12'd0) && (deb_q != 12'd0);
    assign is_digit  = |deb_q[9:0];
    assign is_star   = deb_q[10];
    assign is_hash   = deb_q[11];
    assign expire    = (timer_q <= TW'(1));
    assign fail_inc  = (fail_cnt_q == 4'(MAX_FAIL)) ? fail_cnt_q : fail_cnt_q + 4'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            timer_q      <= '0;
            fail_cnt_q   <= '0;
            lock_rst_n_q <= 1'b0;
            door_q       <= 1'b0;
            lockout_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    lock_rst_n_q <= 1'b1;
                    if (press) begin
                        if (is_digit) begin
                            state_q <= S_ENTRY;
                            cnt_q   <= 4'd1;
                        end else if (is_star) begin
                            state_q <= S_CHANGE;
                            cnt_q   <= 4'd0;
                        end
                    end
                end
                S_ENTRY: begin
                    if (press) begin
                        if (is_hash) begin
                            state_q <= S_IDLE;
                            cnt_q   <= 4'd0;
                        end else if (cnt_q == 4'd5) begin
                            state_q <= S_VERIFY;
                            cnt_q   <= 4'd6;
                            timer_q <= TW'(VERIFY_WAIT);
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                end
                S_CHANGE: begin
                    if (press) begin
                        if (is_hash || cnt_q == 4'd11) begin
                            state_q <= S_IDLE;
                            cnt_q   <= 4'd0;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                end
                S_VERIFY: begin
                    // Success is checked first so it wins over a same-cycle timeout.
                    if (lock_open) begin
                        state_q    <= S_OPEN;
                        fail_cnt_q <= 4'd0;
                        timer_q    <= TW'(OPEN_HOLD);
                        door_q     <= 1'b1;
                    end else if (expire) begin
                        timer_q      <= '0;
                        fail_cnt_q   <= fail_inc;
                        lock_rst_n_q <= 1'b0;
                        if (fail_inc == 4'(MAX_FAIL)) begin
                            state_q   <= S_LOCKOUT;
                            timer_q   <= TW'(LOCKOUT_CYC);
                            lockout_q <= 1'b1;
                        end else begin
                            state_q <= S_RELOCK;
                            timer_q <= TW'(2);
                        end
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                S_OPEN: begin
                    if (expire) begin
                        state_q      <= S_RELOCK;
                        timer_q      <= TW'(2);
                        door_q       <= 1'b0;
                        lock_rst_n_q <= 1'b0;
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                S_RELOCK: begin
                    if (expire) begin
                        state_q      <= S_IDLE;
                        timer_q      <= '0;
                        cnt_q        <= 4'd0;
                        lock_rst_n_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                S_LOCKOUT: begin
                    if (expire) begin
                        state_q      <= S_IDLE;
                        timer_q      <= '0;
                        cnt_q        <= 4'd0;
                        fail_cnt_q   <= 4'd0;
                        lockout_q    <= 1'b0;
                        lock_rst_n_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign lock_rst_n   = lock_rst_n_q;
    assign door_release = door_q;
    assign locked_out   = lockout_q;
    assign alarm        = lockout_q;
    assign fail_cnt     = fail_cnt_q;

endmodule

// File: tb/tb_door_access_ctrl.sv
// Directed bench for door_access_ctrl with small timing parameters; all
// expected values are hand-derived cycle counts relative to key changes.
module tb_door_access_ctrl;

    localparam int DEB = 4;
    localparam int VW  = 32;
    localparam int OH  = 20;
    localparam int LC  = 50;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [11:0] key_raw = 12'd0;
    logic        lock_open = 1'b0;
    logic [11:0] key_out;
    logic        lock_rst_n, door_release, locked_out, alarm;
    logic [3:0]  fail_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    logic [11:0] acc;

    door_access_ctrl #(
        .DEBOUNCE(DEB), .VERIFY_WAIT(VW), .OPEN_HOLD(OH),
        .LOCKOUT_CYC(LC), .MAX_FAIL(3), .TW(24)
    ) dut (
        .clk(clk), .reset_n(reset_n), .key_raw(key_raw), .lock_open(lock_open),
        .key_out(key_out), .lock_rst_n(lock_rst_n), .door_release(door_release),
        .locked_out(locked_out), .alarm(alarm), .fail_cnt(fail_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Key held 8 clocks, then released 8 clocks; the FSM reacts on clock 7.
    task automatic press_key(input logic [11:0] k, input logic [11:0] exp7, input string tag);
        key_raw = k;
        ticks(7);
        $display("press %s key=%03h key_out=%03h fail_cnt=%0d", tag, k, key_out, fail_cnt);
        check(tag, key_out, exp7);
        ticks(1);
        key_raw = 12'd0;
        ticks(8);
    endtask

    // Six '7' presses with no lock_open; leaves the bench 40 clocks after the 6th key.
    task automatic wrong_entry(input logic [3:0] exp_fail);
        for (int i = 0; i < 5; i++) press_key(12'h080, 12'h080, "wrong_key");
        press_key(12'h080, 12'h000, "wrong_6th");
        ticks(24);
        check("fail_cnt_after_fail", fail_cnt, exp_fail);
        check("lock_rst_n_after_fail", lock_rst_n, 1'b0);
        if (exp_fail < 4'd3) begin
            check("no_lockout", locked_out, 1'b0);
            ticks(1);
            check("relock_2clk", lock_rst_n, 1'b1);
        end else begin
            check("locked_out_set", locked_out, 1'b1);
            check("alarm_set", alarm, 1'b1);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_key_out"}, key_out, 12'd0);
        check({tag, "_door"}, door_release, 1'b0);
        check({tag, "_locked_out"}, locked_out, 1'b0);
        check({tag, "_alarm"}, alarm, 1'b0);
        check({tag, "_lock_rst_n"}, lock_rst_n, 1'b0);
        check({tag, "_fail_cnt"}, fail_cnt, 4'd0);
    endtask

    initial begin
        #2 reset_n = 1'b0;
        ticks(3);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        #1 check("lock_rst_n_before_clk", lock_rst_n, 1'b0);
        ticks(1);
        check("lock_rst_n_first_clk", lock_rst_n, 1'b1);

        // Debounce latency, glitch rejection, multi-key rejection
        key_raw = 12'h002;
        ticks(5);
        check("deb_latency_5", key_out, 12'h000);
        ticks(1);
        check("deb_latency_6", key_out, 12'h002);
        ticks(2);
        key_raw = 12'd0;
        ticks(8);
        acc = 12'd0;
        key_raw = 12'h004;
        for (int i = 0; i < 3; i++) begin ticks(1); acc |= key_out; end
        key_raw = 12'd0;
        for (int i = 0; i < 10; i++) begin ticks(1); acc |= key_out; end
        check("glitch_rejected", acc, 12'h000);
        key_raw = 12'h003;
        for (int i = 0; i < 10; i++) begin ticks(1); acc |= key_out; end
        key_raw = 12'd0;
        for (int i = 0; i < 8; i++) begin ticks(1); acc |= key_out; end
        check("multikey_rejected", acc, 12'h000);
        press_key(12'h800, 12'h800, "hash_abort");

        // Correct login, lock core opens 8 clocks after the 6th key
        press_key(12'h002, 12'h002, "d1");
        press_key(12'h004, 12'h004, "d2");
        press_key(12'h008, 12'h008, "d3");
        press_key(12'h010, 12'h010, "d4");
        press_key(12'h020, 12'h020, "d5");
        key_raw = 12'h040;
        ticks(6);
        check("d6_visible", key_out, 12'h040);
        ticks(1);
        check("verify_blocks_keys", key_out, 12'h000);
        ticks(1);
        lock_open = 1'b1;
        key_raw = 12'd0;
        ticks(1);
        lock_open = 1'b0;
        check("door_open", door_release, 1'b1);
        check("lock_rst_n_in_open", lock_rst_n, 1'b1);
        ticks(OH - 1);
        check("door_hold_last", door_release, 1'b1);
        ticks(1);
        check("door_closed", door_release, 1'b0);
        check("relock_low_1", lock_rst_n, 1'b0);
        ticks(1);
        check("relock_low_2", lock_rst_n, 1'b0);
        ticks(1);
        check("relock_done", lock_rst_n, 1'b1);
        check("fail_cnt_success", fail_cnt, 4'd0);

        // One failure, then '#' abort and a 12-key change sequence
        wrong_entry(4'd1);
        press_key(12'h002, 12'h002, "abort_d1");
        press_key(12'h004, 12'h004, "abort_d2");
        press_key(12'h800, 12'h800, "abort_hash");
        check("abort_fail_kept", fail_cnt, 4'd1);
        press_key(12'h400, 12'h400, "change_star");
        for (int i = 0; i < 12; i++) begin
            logic [11:0] k;
            k = (i % 2 == 1) ? 12'h400 : (12'h001 << (i % 10));
            press_key(k, k, "change_key");
        end
        check("change_fail_kept", fail_cnt, 4'd1);
        check("change_no_door", door_release, 1'b0);

        // lock_open coincides with the VERIFY timeout; key held across VERIFY/OPEN
        press_key(12'h002, 12'h002, "e1");
        press_key(12'h004, 12'h004, "e2");
        press_key(12'h008, 12'h008, "e3");
        press_key(12'h010, 12'h010, "e4");
        press_key(12'h020, 12'h020, "e5");
        press_key(12'h040, 12'h000, "e6");
        key_raw = 12'h002;
        ticks(22);
        check("verify_still_closed", door_release, 1'b0);
        check("verify_fail_pending", fail_cnt, 4'd1);
        lock_open = 1'b1;
        ticks(1);
        lock_open = 1'b0;
        check("tie_success_door", door_release, 1'b1);
        check("tie_success_fail0", fail_cnt, 4'd0);
        ticks(22);
        check("held_key_visible_idle", key_out, 12'h002);
        check("held_key_lock_rst_n", lock_rst_n, 1'b1);
        key_raw = 12'd0;
        ticks(8);
        press_key(12'h002, 12'h002, "h1");
        press_key(12'h004, 12'h004, "h2");
        press_key(12'h008, 12'h008, "h3");
        press_key(12'h010, 12'h010, "h4");
        press_key(12'h020, 12'h020, "h5_no_spurious");
        press_key(12'h040, 12'h000, "h6");
        lock_open = 1'b1;
        ticks(1);
        lock_open = 1'b0;
        check("open_before_reset", door_release, 1'b1);
        ticks(3);
        reset_n = 1'b0;
        #1 check_reset_outputs("rst_open");
        @(negedge clk);
        reset_n = 1'b1;
        ticks(1);
        check("rst_open_lock_rst_n", lock_rst_n, 1'b1);
        check("rst_open_door", door_release, 1'b0);

        // Three failures -> lockout with keys blocked, then expiry
        wrong_entry(4'd1);
        wrong_entry(4'd2);
        wrong_entry(4'd3);
        key_raw = 12'h002;
        ticks(8);
        check("lockout_blocks_keys", key_out, 12'h000);
        key_raw = 12'd0;
        ticks(8);
        ticks(32);
        check("lockout_last_clk", locked_out, 1'b1);
        check("lockout_alarm_last", alarm, 1'b1);
        ticks(1);
        check("lockout_end", locked_out, 1'b0);
        check("lockout_alarm_end", alarm, 1'b0);
        check("lockout_fail_clr", fail_cnt, 4'd0);
        check("lockout_lock_rst_n", lock_rst_n, 1'b1);
        press_key(12'h800, 12'h800, "post_lockout_hash");

        // Reset in the middle of a lockout
        wrong_entry(4'd1);
        wrong_entry(4'd2);
        wrong_entry(4'd3);
        ticks(5);
        reset_n = 1'b0;
        #1 check_reset_outputs("rst_lockout");
        @(negedge clk);
        reset_n = 1'b1;
        ticks(1);
        check("rst_lockout_lock_rst_n", lock_rst_n, 1'b1);
        check("rst_lockout_locked_out", locked_out, 1'b0);
        press_key(12'h002, 12'h002, "post_reset_key");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
